// File: rtl/risc_v_multicycle.sv
// Multi-cycle RV32I-subset core with a single request/ready memory port.
// Each instruction walks FETCH/DECODE/EXECUTE/MEM/WB; illegal encodings park the core in HALT.
module risc_v_multicycle #(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] a0,
  output logic                  halted,
  output logic [31:0]           instret
);

  typedef enum logic [2:0] {StFetch, StDecode, StExecute, StMem, StWb, StHalt} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [31:0]           ir_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, imm_q, alu_q, mdr_q, a0_q;
  logic [DATA_WIDTH-1:0] rf_q [32];
  logic                  halted_q, run_q;
  logic [31:0]           instret_q;

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  logic is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_jal, is_lui, legal;
  assign is_r    = (opcode == 7'b0110011) &&
                   ((funct7 == 7'b0000000 && (funct3 == 3'b000 || funct3 == 3'b111 ||
                                              funct3 == 3'b110 || funct3 == 3'b010)) ||
                    (funct7 == 7'b0100000 && funct3 == 3'b000));
  assign is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_lw   = (opcode == 7'b0000011) && (funct3 == 3'b010);
  assign is_sw   = (opcode == 7'b0100011) && (funct3 == 3'b010);
  assign is_beq  = (opcode == 7'b1100011) && (funct3 == 3'b000);
  assign is_bne  = (opcode == 7'b1100011) && (funct3 == 3'b001);
  assign is_jal  = (opcode == 7'b1101111);
  assign is_lui  = (opcode == 7'b0110111);
  assign legal   = is_r | is_addi | is_lw | is_sw | is_beq | is_bne | is_jal | is_lui;

  logic [DATA_WIDTH-1:0] imm_c;
  always_comb begin
    imm_c = '0;
    case (opcode)
      7'b0010011, 7'b0000011: imm_c = {{20{ir_q[31]}}, ir_q[31:20]};
      7'b0100011: imm_c = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      7'b1100011: imm_c = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      7'b1101111: imm_c = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      7'b0110111: imm_c = {ir_q[31:12], 12'b0};
      default:    imm_c = '0;
    endcase
  end

  logic [DATA_WIDTH-1:0] alu_c;
  always_comb begin
    alu_c = a_q + imm_q;
    if (is_lui) begin
      alu_c = imm_q;
    end else if (is_r) begin
      case (funct3)
        3'b000:  alu_c = funct7[5] ? (a_q - b_q) : (a_q + b_q);
        3'b111:  alu_c = a_q & b_q;
        3'b110:  alu_c = a_q | b_q;
        3'b010:  alu_c = DATA_WIDTH'($signed(a_q) < $signed(b_q));
        default: alu_c = '0;
      endcase
    end
  end

  logic [ADDR_WIDTH-1:0] pc_plus4, pc_imm;
  logic                  branch_taken;
  assign pc_plus4     = pc_q + ADDR_WIDTH'(4);
  assign pc_imm       = pc_q + imm_q[ADDR_WIDTH-1:0];
  assign branch_taken = is_beq ? (a_q == b_q) : (a_q != b_q);

  // run_q holds off the first fetch until one clean cycle after reset.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == StFetch && run_q) begin
      mem_req  = 1'b1;
      mem_addr = {pc_q[ADDR_WIDTH-1:2], 2'b00};
    end else if (state_q == StMem) begin
      mem_req  = 1'b1;
      mem_we   = is_sw;
      mem_addr = {alu_q[ADDR_WIDTH-1:2], 2'b00};
      if (is_sw) mem_wdata = b_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      a0_q      <= '0;
      halted_q  <= 1'b0;
      run_q     <= 1'b0;
      instret_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      run_q <= 1'b1;
      a0_q  <= rf_q[10];
      unique case (state_q)
        StFetch: begin
          if (run_q && mem_ready) begin
            ir_q    <= mem_rdata[31:0];
            state_q <= StDecode;
          end
        end
        StDecode: begin
          a_q      <= rf_q[rs1];
          b_q      <= rf_q[rs2];
          imm_q    <= imm_c;
          halted_q <= !legal;
          state_q  <= legal ? StExecute : StHalt;
        end
        StExecute: begin
          if (is_beq || is_bne) begin
            pc_q      <= branch_taken ? pc_imm : pc_plus4;
            instret_q <= instret_q + 32'd1;
            state_q   <= StFetch;
          end else if (is_jal) begin
            if (rd != 5'd0) rf_q[rd] <= DATA_WIDTH'(pc_plus4);
            pc_q      <= pc_imm;
            instret_q <= instret_q + 32'd1;
            state_q   <= StFetch;
          end else begin
            alu_q   <= alu_c;
            state_q <= (is_lw || is_sw) ? StMem : StWb;
          end
        end
        StMem: begin
          if (mem_ready) begin
            if (is_sw) begin
              pc_q      <= pc_plus4;
              instret_q <= instret_q + 32'd1;
              state_q   <= StFetch;
            end else begin
              mdr_q   <= mem_rdata;
              state_q <= StWb;
            end
          end
        end
        StWb: begin
          if (rd != 5'd0) rf_q[rd] <= is_lw ? mdr_q : alu_q;
          pc_q      <= pc_plus4;
          instret_q <= instret_q + 32'd1;
          state_q   <= StFetch;
        end
        StHalt: state_q <= StHalt;
        default: state_q <= StFetch;
      endcase
    end
  end

  assign a0      = a0_q;
  assign halted  = halted_q;
  assign instret = instret_q;

endmodule
